// File: rtl/axi_lite_pkg.sv
// Shared definitions for the ALU slave: op codes, bus field positions,
// FSM state types and per-unit default latencies.
package axi_lite_pkg;

  // ALU operation codes carried in IN[11:8]; 9..15 produce a zero result
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_PASS = 4'd8;

  // Read request IN = {ID, OP, SRCA, SRCB}
  localparam int IN_ID_LO   = 12;
  localparam int IN_OP_LO   = 8;
  localparam int IN_SRCA_LO = 4;
  localparam int IN_SRCB_LO = 0;

  // Write address AWIN = {ID, ADDR, LEN}
  localparam int AW_ID_LO   = 8;
  localparam int AW_ADDR_LO = 4;
  localparam int AW_LEN_LO  = 0;

  // Write response BRESP = {ID, ERR}
  localparam int BRESP_ID_LO = 1;
  localparam int BRESP_ERR   = 0;

  // Default response latencies per unit type
  localparam logic [4:0] DELAY_ALU = 5'd10;
  localparam logic [4:0] DELAY_MEM = 5'd20;
  localparam logic [4:0] DELAY_IO  = 5'd30;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_WAIT = 2'd2,
    W_RESP = 2'd3
  } wstate_e;

  // A programmed latency of zero still costs one cycle
  function automatic logic [4:0] eff_delay(input logic [4:0] d);
    return (d == 5'd0) ? 5'd1 : d;
  endfunction

endpackage

// File: rtl/alu_slave_delay_counter.sv
// Loadable down-counter that stretches a channel's response; done marks
// the final wait cycle.
module delay_counter
  import axi_lite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] load_val,
  input  logic       en,
  output logic       done
);

  logic [4:0] count;

  // Load the clamped latency, then count down and park at 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 5'd0;
    end else if (load) begin
      count <= eff_delay(load_val);
    end else if (en && (count > 5'd1)) begin
      count <= count - 5'd1;
    end
  end

  assign done = (count == 5'd1);

endmodule

// File: rtl/alu_slave.sv
// Bus-style ALU slave: 16x8 operand register file filled by a burst write
// channel, single-beat ALU reads, each response stretched by DELAY.
module alu_slave
  import axi_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ARVALID,
  output logic        ARREADY,
  input  logic [15:0] IN,
  output logic        RVALID,
  input  logic        RREADY,
  output logic        RLAST,
  output logic [8:0]  OUT,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [11:0] AWIN,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [7:0]  WDATA,
  input  logic        WLAST,
  output logic        BVALID,
  input  logic        BREADY,
  output logic [4:0]  BRESP,
  input  logic [4:0]  DELAY,
  output logic        RIDLE,
  output logic        WIDLE,
  output logic        RIDLE_prev,
  output logic        WIDLE_prev
);

  logic [7:0] regs [16];

  rstate_e    r_state;
  logic [3:0] rd_id;
  logic [3:0] rd_op;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       r_load;
  logic       r_en;
  logic       r_done;

  wstate_e    w_state;
  logic [3:0] wr_id;
  logic [3:0] wr_addr;
  logic [3:0] wr_len;
  logic [3:0] beat;
  logic       w_beat;
  logic       w_end;
  logic       w_err;
  logic       w_en;
  logic       w_done;

  // The read response carries no ID, so the latched read ID is informational
  logic unused_rd_id;
  assign unused_rd_id = ^rd_id;

  function automatic logic [8:0] alu_result(input logic [3:0] op,
                                            input logic [7:0] a,
                                            input logic [7:0] b);
    logic [8:0] res;
    case (op)
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_NOT:  res = {1'b0, ~a};
      OP_SHL:  res = {a[7], a[6:0], 1'b0};
      OP_SHR:  res = {a[0], 1'b0, a[7:1]};
      OP_PASS: res = {1'b0, a};
      default: res = 9'd0;
    endcase
    return res;
  endfunction

  assign r_load = (r_state == R_IDLE) && ARVALID;
  assign r_en   = (r_state == R_WAIT);

  assign w_beat = (w_state == W_DATA) && WVALID;
  assign w_end  = w_beat && (WLAST || (beat == wr_len));
  assign w_err  = !(WLAST && (beat == wr_len));
  assign w_en   = (w_state == W_WAIT);

  delay_counter u_rd_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (r_load),
    .load_val (DELAY),
    .en       (r_en),
    .done     (r_done)
  );

  delay_counter u_wr_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (w_end),
    .load_val (DELAY),
    .en       (w_en),
    .done     (w_done)
  );

  // Register file: burst beats write at ADDR+beat, wrapping within 16 entries
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
    end else if (w_beat) begin
      regs[wr_addr + beat] <= WDATA;
    end
  end

  // Read FSM: sample operands at accept, compute after the delay, hold until RREADY
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b1;
      RVALID  <= 1'b0;
      OUT     <= 9'd0;
      rd_id   <= 4'd0;
      rd_op   <= 4'd0;
      op_a    <= 8'd0;
      op_b    <= 8'd0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID) begin
            rd_id   <= IN[IN_ID_LO +: 4];
            rd_op   <= IN[IN_OP_LO +: 4];
            op_a    <= regs[IN[IN_SRCA_LO +: 4]];
            op_b    <= regs[IN[IN_SRCB_LO +: 4]];
            ARREADY <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_done) begin
            OUT     <= alu_result(rd_op, op_a, op_b);
            RVALID  <= 1'b1;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: begin
          RVALID  <= 1'b0;
          ARREADY <= 1'b1;
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Write FSM: accept address, take beats until WLAST or LEN+1, then delayed response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      AWREADY <= 1'b1;
      WREADY  <= 1'b0;
      BVALID  <= 1'b0;
      BRESP   <= 5'd0;
      wr_id   <= 4'd0;
      wr_addr <= 4'd0;
      wr_len  <= 4'd0;
      beat    <= 4'd0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID) begin
            wr_id   <= AWIN[AW_ID_LO +: 4];
            wr_addr <= AWIN[AW_ADDR_LO +: 4];
            wr_len  <= AWIN[AW_LEN_LO +: 4];
            beat    <= 4'd0;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_end) begin
            BRESP[BRESP_ID_LO +: 4] <= wr_id;
            BRESP[BRESP_ERR]        <= w_err;
            WREADY  <= 1'b0;
            w_state <= W_WAIT;
          end else if (w_beat) begin
            beat <= beat + 4'd1;
          end
        end
        W_WAIT: begin
          if (w_done) begin
            BVALID  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: begin
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
          AWREADY <= 1'b1;
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  assign RLAST = RVALID;
  assign RIDLE = (r_state == R_IDLE);
  assign WIDLE = (w_state == W_IDLE);

  // One-cycle-old idle copies so the master can spot an idle rising edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RIDLE_prev <= 1'b1;
      WIDLE_prev <= 1'b1;
    end else begin
      RIDLE_prev <= RIDLE;
      WIDLE_prev <= WIDLE;
    end
  end

endmodule

// File: tb/tb_alu_slave.sv
// Self-checking bench for alu_slave: directed cases plus randomized traffic
// against a register-file / arithmetic reference model.
module tb_alu_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST;
  logic [15:0] IN;
  logic [8:0]  OUT;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic [11:0] AWIN;
  logic [7:0]  WDATA;
  logic [4:0]  BRESP, DELAY;
  logic        RIDLE, WIDLE, RIDLE_prev, WIDLE_prev;

  int errs = 0;
  int checks = 0;

  logic [7:0] mregs [16];
  logic [7:0] wbuf [16];
  logic last_r = 1'b1;
  logic last_w = 1'b1;

  always #5 clk = ~clk;

  alu_slave dut (
    .clk(clk), .rst(rst),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .IN(IN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .OUT(OUT),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWIN(AWIN),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .DELAY(DELAY),
    .RIDLE(RIDLE), .WIDLE(WIDLE), .RIDLE_prev(RIDLE_prev), .WIDLE_prev(WIDLE_prev)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic
  function automatic logic [8:0] ref_alu(input int op, input int a, input int b);
    int r;
    case (op)
      0: r = a + b;
      1: r = ((a < b) ? 256 : 0) + ((a - b) & 255);
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 255 - a;
      6: r = a * 2;
      7: r = (a % 2) * 256 + a / 2;
      8: r = a;
      default: r = 0;
    endcase
    return r[8:0];
  endfunction

  // Idle history and RLAST mirror, observed every cycle outside reset
  always @(negedge clk) begin
    if (rst) begin
      chk("ridle_prev", RIDLE_prev, last_r);
      chk("widle_prev", WIDLE_prev, last_w);
      chk("rlast_eq_rvalid", RLAST, RVALID);
    end
    last_r = RIDLE;
    last_w = WIDLE;
  end

  // Caller is at a negedge with the read channel idle
  task automatic do_read(input int id, input int op, input int sa, input int sb,
                         input int dly, input int hold, input bit scramble);
    logic [8:0] exp;
    int lat, cyc;
    exp = ref_alu(op, mregs[sa], mregs[sb]);
    lat = (dly == 0) ? 1 : dly;
    chk("arready", ARREADY, 1);
    IN = {id[3:0], op[3:0], sa[3:0], sb[3:0]};
    DELAY = dly[4:0];
    ARVALID = 1'b1;
    @(negedge clk);
    ARVALID = 1'b0;
    if (scramble) DELAY = 5'($urandom);
    chk("rvalid_early", RVALID, 0);
    cyc = 0;
    while (RVALID !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("r_latency", cyc, lat);
    chk("r_out", OUT, exp);
    chk("rlast", RLAST, 1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("r_hold_out", OUT, exp);
      chk("r_hold_valid", RVALID, 1);
    end
    RREADY = 1'b1;
    @(negedge clk);
    RREADY = 1'b0;
    chk("r_after_valid", RVALID, 0);
    chk("r_after_idle", RIDLE, 1);
  endtask

  // Caller is at a negedge with the write channel idle; data comes from wbuf
  task automatic do_write(input int id, input int addr, input int len, input int wlast_at,
                          input int dly, input bit extra, input bit scramble);
    int nb, lat, cyc;
    bit err;
    nb  = (wlast_at >= 0 && wlast_at < len) ? wlast_at + 1 : len + 1;
    err = (wlast_at != len);
    lat = (dly == 0) ? 1 : dly;
    chk("awready", AWREADY, 1);
    AWIN = {id[3:0], addr[3:0], len[3:0]};
    DELAY = dly[4:0];
    AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    for (int b = 0; b < nb; b++) begin
      WVALID = 1'b1;
      WDATA  = wbuf[b];
      WLAST  = (b == wlast_at);
      chk("wready", WREADY, 1);
      @(negedge clk);
      mregs[(addr + b) % 16] = wbuf[b];
    end
    WVALID = 1'b0;
    WLAST  = 1'b0;
    if (scramble) DELAY = 5'($urandom);
    if (extra) begin
      WVALID = 1'b1;
      WDATA  = 8'hAA;
      chk("wready_after_end", WREADY, 0);
    end
    cyc = 0;
    while (BVALID !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      WVALID = 1'b0;
      cyc++;
    end
    WVALID = 1'b0;
    chk("b_latency", cyc, lat);
    chk("bresp", BRESP, {id[3:0], err});
    @(negedge clk);
    chk("b_hold_valid", BVALID, 1);
    chk("b_hold_resp", BRESP, {id[3:0], err});
    BREADY = 1'b1;
    @(negedge clk);
    BREADY = 1'b0;
    chk("b_after_valid", BVALID, 0);
    chk("b_after_idle", WIDLE, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_arready", ARREADY, 1);
    chk("rst_awready", AWREADY, 1);
    chk("rst_ridle", RIDLE, 1);
    chk("rst_widle", WIDLE, 1);
    chk("rst_ridle_prev", RIDLE_prev, 1);
    chk("rst_widle_prev", WIDLE_prev, 1);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_out", OUT, 0);
    chk("rst_bresp", BRESP, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, wl, kind;
    rst = 1'b0;
    ARVALID = 0; RREADY = 0; IN = '0;
    AWVALID = 0; AWIN = '0; WVALID = 0; WDATA = '0; WLAST = 0; BREADY = 0;
    DELAY = 5'd10;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    #2 rst = 1'b1;
    @(negedge clk);

    // Directed burst write then ADD/SUB reads
    wbuf[0] = 8'hF0; wbuf[1] = 8'h20;
    do_write(1, 2, 1, 1, 10, 0, 0);
    do_read(5, 0, 2, 3, 10, 0, 0);
    chk("add_const", OUT, 9'h110);
    do_read(5, 1, 2, 3, 10, 0, 0);
    chk("sub_const", OUT, 9'h0D0);

    // Burst errors, extra beat rejected, address wrap
    for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
    do_write(2, 4, 3, 1, 3, 0, 0);
    do_write(3, 8, 0, -1, 2, 1, 0);
    wbuf[0] = 8'h3C; wbuf[1] = 8'hC3;
    do_write(4, 15, 1, 1, 4, 0, 0);
    do_read(0, 8, 0, 0, 2, 0, 0);
    chk("wrap_reg0", OUT, 9'h0C3);
    do_read(0, 8, 9, 9, 2, 0, 0);

    // Backpressure, DELAY sampled only at accept
    do_read(1, 4, 2, 15, 7, 5, 1);
    do_write(9, 10, 2, 2, 5, 0, 1);

    // Read accepted in the same cycle as a write beat to the same register
    wbuf[0] = 8'h77;
    fork
      do_write(7, 2, 0, 0, 6, 0, 0);
      begin
        @(negedge clk);
        do_read(8, 8, 2, 2, 6, 0, 0);
        chk("concurrent_old", OUT, 9'h0F0);
      end
    join
    do_read(8, 8, 2, 2, 3, 0, 0);
    chk("concurrent_new", OUT, 9'h077);

    // Zero DELAY behaves as one
    do_read(2, 6, 15, 2, 0, 0, 0);
    do_write(5, 6, 0, 0, 0, 0, 0);

    // Reset in the middle of a burst
    AWIN = {4'h6, 4'h3, 4'h3};
    DELAY = 5'd5;
    AWVALID = 1'b1;
    @(negedge clk);
    AWVALID = 1'b0;
    WVALID = 1'b1; WDATA = 8'h5A;
    @(negedge clk);
    WVALID = 1'b0;
    #2 rst = 1'b0;
    for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
    @(negedge clk);
    chk_reset_outputs();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_read(0, 8, 3, 3, 1, 0, 0);
    chk("reg3_after_reset", OUT, 9'h000);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(1, 0);
      if (kind == 0) begin
        do_read($urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0),
                $urandom_range(15, 0), $urandom_range(31, 0), $urandom_range(3, 0),
                1'($urandom_range(1, 0)));
      end else begin
        for (int i = 0; i < 16; i++) wbuf[i] = 8'($urandom);
        len = $urandom_range(15, 0);
        case ($urandom_range(3, 0))
          0: wl = -1;
          1: wl = $urandom_range(len, 0);
          default: wl = len;
        endcase
        do_write($urandom_range(15, 0), $urandom_range(15, 0), len, wl,
                 $urandom_range(31, 0), 1'($urandom_range(1, 0)),
                 1'($urandom_range(1, 0)));
      end
    end

    // Sweep the whole register file through PASS
    for (int i = 0; i < 16; i++) do_read(0, 8, i, 0, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_slave.md
# alu_slave

Bus-style ALU slave for the top-level controller's ALU master port. It holds a 16×8 operand register file, loaded through a burst write channel. It computes 9-bit results on single-beat read requests. Both channels run as independent handshake FSMs, and each response is stretched by a programmable `DELAY` so the controller sees unit-specific latency. IDLE flags and their one-cycle-old copies let the master detect transaction completion.

## Interface
Parameters: none; latency comes from the `DELAY` port.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ARVALID` in 1: read-request valid.
- `ARREADY` out 1: read-request accept.
- `IN` in 16: read request `{ID[15:12], OP[11:8], SRCA[7:4], SRCB[3:0]}`.
- `RVALID` out 1: result valid.
- `RREADY` in 1: master accepts result.
- `RLAST` out 1: equals `RVALID`; reads are single-beat.
- `OUT` out 9: result `{carry/borrow, data[7:0]}`.
- `AWVALID` in 1: write-address valid.
- `AWREADY` out 1: write-address accept.
- `AWIN` in 12: `{ID[11:8], ADDR[7:4], LEN[3:0]}`; the burst is LEN+1 beats.
- `WVALID` in 1: write-data valid.
- `WREADY` out 1: write-data accept.
- `WDATA` in 8: write data.
- `WLAST` in 1: final beat.
- `BVALID` out 1: write response valid.
- `BREADY` in 1: master accepts the response.
- `BRESP` out 5: `{ID[3:0], ERR}`.
- `DELAY` in 5: response latency in cycles; 0 is treated as 1.
- `RIDLE` out 1: read FSM is in R_IDLE.
- `WIDLE` out 1: write FSM is in W_IDLE.
- `RIDLE_prev` out 1: `RIDLE` registered one cycle.
- `WIDLE_prev` out 1: `WIDLE` registered one cycle.

## Operation
Read FSM:
- States and transitions: R_IDLE → R_WAIT → R_RESP → R_IDLE.
- R_IDLE: `ARREADY`=1. On `ARVALID`, latch ID and OP, latch the register values at SRCA (A) and SRCB (B), load the counter with max(`DELAY`,1), and go to R_WAIT.
- R_WAIT: decrement the counter each cycle. When it reaches 1, register the result into `OUT` and go to R_RESP.
- R_RESP: `RVALID`=`RLAST`=1 and `OUT` is held stable. On `RREADY`, go to R_IDLE.

OP encoding (9-bit result):
- 0: ADD, A+B with carry.
- 1: SUB, A−B with bit 8 = borrow.
- 2: AND. 3: OR. 4: XOR.
- 5: NOT A.
- 6: SHL A, bit 8 = A[7].
- 7: SHR A, bit 8 = A[0].
- 8: pass A.
- 9–15: result 0.
- For logic ops, bit 8 = 0.

Write FSM:
- States and transitions: W_IDLE → W_DATA → W_WAIT → W_RESP → W_IDLE.
- W_IDLE: `AWREADY`=1. On `AWVALID`, latch ID, ADDR and LEN, clear the beat count, and go to W_DATA.
- W_DATA: `WREADY`=1. Each beat with `WVALID` writes `WDATA` to reg[ADDR+beat], wrapping mod 16.
- The burst ends on a `WLAST` beat, or after LEN+1 beats, whichever comes first. Extra beats are never accepted.
- ERR=1 when `WLAST` does not coincide with beat LEN+1. That covers `WLAST` early, and LEN+1 beats reached without `WLAST`.
- At burst end, load the counter with max(`DELAY`,1) and go to W_WAIT, then W_RESP.
- W_RESP: `BVALID`=1 with `BRESP` held. On `BREADY`, go to W_IDLE.

Channel interaction:
- The channels are fully independent and may be active at the same time.
- Read operands are sampled at address accept. A later write does not change an in-flight result.
- A write to a register in the same cycle as a read accept: the read sees the old value.

## Timing
Reset:
- All outputs go to 0 except `ARREADY`=`AWREADY`=`RIDLE`=`WIDLE`=`RIDLE_prev`=`WIDLE_prev`=1.
- The register file clears to 0 and both FSMs go to idle.
- A reset mid-transaction aborts it; no response is issued.

Latency:
- Read accepted at edge k: `RVALID` is high after edge k+max(`DELAY`,1).
- Write: `BVALID` is high max(`DELAY`,1) edges after the final data beat.
- `DELAY` is sampled only at address accept (read) or burst end (write).
- Valid outputs stay high until ready; with ready already high, the valid is a one-cycle pulse.
- Back-to-back: a new request is accepted at the earliest one cycle after the response handshake, because the FSM is in the IDLE state again.

IDLE flags:
- `RIDLE`/`WIDLE` are combinational from state.
- `*_prev` lag by exactly one cycle. `*_IDLE & ~*_IDLE_prev` marks completion.

## Structure
- Shared package `axi_lite_pkg` holds:
  - ALU OP encodings;
  - field positions of `IN`, `AWIN` and `BRESP`;
  - state enums;
  - default delay constants: ALU 10, MEM 20, IO 30.
- One natural sub-module, `delay_counter`: a loadable down-counter with a done flag, instantiated once per channel.
- The register file is inline.

## Test plan
1. Reset: assert `rst`=0 mid-burst, then release. All idle flags are 1, `RVALID`=`BVALID`=0, and reading reg 3 with OP=8 returns 0.
2. Write: AWIN=`{1,4'h2,4'h1}`, WDATA 0xF0 then 0x20 with `WLAST`. Reg2=0xF0, reg3=0x20, BRESP=`{1,0}`, and `BVALID` is high 10 cycles after `WLAST` with `DELAY`=10.
3. Read: IN=`{5,0,2,3}` (ADD) with `DELAY`=10. `OUT`=0x110, `RVALID`=`RLAST`=1 exactly 10 edges after accept. SUB (OP=1) gives 0x0D0.
4. Burst error: LEN=3 with `WLAST` on beat 2 gives ERR=1. LEN=0 without `WLAST` ends after 1 beat with ERR=1. ADDR=15 with LEN=1 wraps to reg 0.
5. Backpressure and concurrency: hold `RREADY`=0 for 5 cycles and check `OUT` is stable. Overlap a read and a write; the read returns the pre-write value.
6. `DELAY`=0 behaves as 1. `RIDLE_prev` trails `RIDLE` by one cycle at every transition.
